// File: rtl/tipi_bus_pkg.sv
// rtl/tipi_bus_pkg.sv - shared register selects, FSM states and nibble indices for the TIPI nibble-bus master
package tipi_bus_pkg;

  localparam logic [1:0] REG_TD = 2'd0;
  localparam logic [1:0] REG_TC = 2'd1;
  localparam logic [1:0] REG_RD = 2'd2;
  localparam logic [1:0] REG_RC = 2'd3;

  localparam logic [1:0] NIB_SEL = 2'd0;
  localparam logic [1:0] NIB_HI  = 2'd1;
  localparam logic [1:0] NIB_LO  = 2'd2;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_BRST_H,
    ST_BRST_L,
    ST_SETUP,
    ST_CLKH,
    ST_CLKL,
    ST_TURN,
    ST_DONE
  } state_t;

  // TD/TC are readable, RD/RC are writable: the upper select bit gives the direction.
  function automatic logic is_legal(input logic write, input logic [1:0] sel);
    return write == sel[1];
  endfunction

endpackage

// File: rtl/tipi_4bit_bus_master_if.sv
// rtl/tipi_4bit_bus_master_if.sv - host request/response and nibble-bus signal bundle
interface tipi_4bit_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_reg;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       bus_clk;
  logic       bus_reset;
  logic [3:0] bus_data_o;
  logic       bus_data_oe;
  logic [3:0] bus_data_i;

  modport master (
    input  req_valid, req_write, req_reg, req_wdata, bus_data_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_clk, bus_reset, bus_data_o, bus_data_oe
  );

  modport slave (
    output req_valid, req_write, req_reg, req_wdata, bus_data_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_clk, bus_reset, bus_data_o, bus_data_oe
  );
endinterface

// File: rtl/tipi_bus_phase_timer.sv
// rtl/tipi_bus_phase_timer.sv - per-phase down-counter, phase_done when the count reaches zero
module tipi_bus_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  output logic o_phase_done
);

  localparam int W = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CLK_DIV - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= LOAD_VAL;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_phase_done = (r_count == '0);

endmodule

// File: rtl/tipi_4bit_bus_master.sv
// rtl/tipi_4bit_bus_master.sv - TIPI 4-bit nibble-bus initiator; TIPI_BUS_FRAME_RESET_EN adds a bus reset pulse per transaction
module tipi_4bit_bus_master
  import tipi_bus_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  tipi_4bit_bus_master_if.master        bus
);

`ifdef TIPI_BUS_FRAME_RESET_EN
  localparam state_t FIRST_ST = ST_BRST_H;
`else
  localparam state_t FIRST_ST = ST_SETUP;
`endif

  state_t     r_state;
  logic [1:0] r_nib;
  logic       r_init_low;
  logic       r_write;
  logic [1:0] r_reg;
  logic [7:0] r_wdata;
  logic       r_err;
  logic [7:0] r_rdata_sh;

  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic       r_bus_clk;
  logic       r_bus_reset;
  logic [3:0] r_bus_data_o;
  logic       r_bus_data_oe;

  logic       w_phase_done;
  logic       w_accept;
  logic       w_load;
  logic       w_oe;
  logic [3:0] w_drive_nib;

  assign w_accept = (r_state == ST_IDLE) && r_req_ready && bus.req_valid;
  assign w_load   = (r_state == ST_IDLE) || (r_state == ST_DONE) || w_phase_done;

  // Reads release the bus after the select nibble; writes keep driving through all three.
  assign w_oe = (r_state == ST_SETUP) ||
                (((r_state == ST_CLKH) || (r_state == ST_CLKL)) && (r_write || (r_nib == NIB_SEL)));

  always_comb begin
    w_drive_nib = r_wdata[3:0];
    case (r_nib)
      NIB_SEL: w_drive_nib = {2'b00, r_reg};
      NIB_HI:  w_drive_nib = r_wdata[7:4];
      default: w_drive_nib = r_wdata[3:0];
    endcase
  end

  tipi_bus_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_load),
    .o_phase_done (w_phase_done)
  );

  // Outputs are registered from the current state, so every bus phase appears one cycle after its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      r_nib         <= NIB_SEL;
      r_init_low    <= 1'b0;
      r_write       <= 1'b0;
      r_reg         <= 2'd0;
      r_wdata       <= 8'h00;
      r_err         <= 1'b0;
      r_rdata_sh    <= 8'h00;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 8'h00;
      r_rsp_err     <= 1'b0;
      r_bus_clk     <= 1'b0;
      r_bus_reset   <= 1'b1;
      r_bus_data_o  <= 4'h0;
      r_bus_data_oe <= 1'b0;
    end else begin
      r_bus_clk     <= (r_state == ST_CLKH);
      r_bus_reset   <= ((r_state == ST_INIT) && !r_init_low) || (r_state == ST_BRST_H);
      r_bus_data_oe <= w_oe;
      r_bus_data_o  <= w_oe ? w_drive_nib : 4'h0;
      r_rsp_valid   <= (r_state == ST_DONE);
      r_req_ready   <= (r_state == ST_IDLE) && !w_accept;

      if (r_state == ST_DONE) begin
        r_rsp_err <= r_err;
        if (!r_err && !r_write) begin
          r_rsp_rdata <= r_rdata_sh;
        end
      end

      case (r_state)
        ST_INIT: begin
          if (w_phase_done) begin
            if (!r_init_low) begin
              r_init_low <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= bus.req_write;
            r_reg   <= bus.req_reg;
            r_wdata <= bus.req_wdata;
            r_nib   <= NIB_SEL;
            r_err   <= !is_legal(bus.req_write, bus.req_reg);
            r_state <= is_legal(bus.req_write, bus.req_reg) ? FIRST_ST : ST_DONE;
          end
        end
        ST_BRST_H: if (w_phase_done) r_state <= ST_BRST_L;
        ST_BRST_L: if (w_phase_done) r_state <= ST_SETUP;
        ST_SETUP:  if (w_phase_done) r_state <= ST_CLKH;
        ST_CLKH:   if (w_phase_done) r_state <= ST_CLKL;
        ST_CLKL: begin
          if (w_phase_done) begin
            if (r_write) begin
              if (r_nib == NIB_LO) begin
                r_state <= ST_DONE;
              end else begin
                r_nib   <= r_nib + 2'd1;
                r_state <= ST_SETUP;
              end
            end else if (r_nib == NIB_SEL) begin
              r_nib   <= NIB_HI;
              r_state <= ST_TURN;
            end else begin
              r_rdata_sh[3:0] <= bus.bus_data_i;
              r_state         <= ST_DONE;
            end
          end
        end
        ST_TURN: begin
          if (w_phase_done) begin
            r_rdata_sh[7:4] <= bus.bus_data_i;
            r_state         <= ST_CLKH;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.bus_clk     = r_bus_clk;
  assign bus.bus_reset   = r_bus_reset;
  assign bus.bus_data_o  = r_bus_data_o;
  assign bus.bus_data_oe = r_bus_data_oe;

endmodule

// File: tb/tb_tipi_4bit_bus_master.sv
// tb/tb_tipi_4bit_bus_master.sv - scoreboard bench with a behavioural nibble-bus slave on the far end
module tb_tipi_4bit_bus_master;
  import tipi_bus_pkg::*;

  localparam int CD = 2;
`ifdef TIPI_BUS_FRAME_RESET_EN
  localparam int BRST_PHASES = 2;
  localparam int RST_PER_TXN = 1;
`else
  localparam int BRST_PHASES = 0;
  localparam int RST_PER_TXN = 0;
`endif
  localparam int LAT_W = (9 + BRST_PHASES) * CD + 1;
  localparam int LAT_R = (6 + BRST_PHASES) * CD + 1;
  localparam logic [7:0] TD_VAL = 8'hA5;
  localparam logic [7:0] TC_VAL = 8'h5A;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tipi_4bit_bus_master_if bus();

  tipi_4bit_bus_master #(.CLK_DIV(CD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic [7:0] m_rdata = 8'h00;

  // Far-end slave: select on first clock, then two data nibbles; resyncs after each frame.
  int         s_phase = 0;
  logic [1:0] s_sel = 2'd0;
  logic       s_low = 1'b0;
  logic [3:0] s_hi = 4'h0;
  logic [7:0] s_rd = 8'h00;
  logic [7:0] s_rc = 8'h00;
  logic [7:0] s_val;

  always @(posedge bus.bus_clk or posedge bus.bus_reset) begin
    if (bus.bus_reset) begin
      s_phase <= 0;
    end else begin
      case (s_phase)
        0: begin s_sel <= bus.bus_data_o[1:0]; s_low <= 1'b0; s_phase <= 1; end
        1: begin
          if (s_sel[1]) begin s_hi <= bus.bus_data_o; s_phase <= 2; end
          else begin s_low <= 1'b1; s_phase <= 0; end
        end
        default: begin
          if (s_sel == REG_RD) s_rd <= {s_hi, bus.bus_data_o};
          else s_rc <= {s_hi, bus.bus_data_o};
          s_phase <= 0;
        end
      endcase
    end
  end

  assign s_val = (s_sel == REG_TD) ? TD_VAL : (s_sel == REG_TC) ? TC_VAL : (s_sel == REG_RD) ? s_rd : s_rc;
  assign bus.bus_data_i = s_low ? s_val[3:0] : s_val[7:4];

  int         clk_rises = 0;
  int         rst_rises = 0;
  int         oe_hi = 0;
  int         rsp_cnt = 0;
  int         viol = 0;
  logic [3:0] nib_log[$];
  logic       oe_log[$];
  logic       p_clk = 1'b0;
  logic       p_oe = 1'b0;

  always @(posedge bus.bus_clk) begin
    clk_rises++;
    nib_log.push_back(bus.bus_data_o);
    oe_log.push_back(bus.bus_data_oe);
  end
  always @(posedge bus.bus_reset) rst_rises++;
  always @(negedge clk) begin
    if (bus.bus_data_oe === 1'b1) oe_hi++;
    if (bus.rsp_valid === 1'b1) rsp_cnt++;
    if (reset_n && (bus.bus_clk !== p_clk) && (bus.bus_data_oe !== p_oe)) viol++;
    p_clk = bus.bus_clk;
    p_oe  = bus.bus_data_oe;
  end

  task automatic issue(input logic w, input logic [1:0] r, input logic [7:0] d, input bit push);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin got = 1'b1; break; end
    end
    n_total++;
    if (!got) $display("FAIL issue_ready got 0 exp 1 (timeout)"); else n_pass++;
    bus.req_write = w; bus.req_reg = r; bus.req_wdata = d; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (push) begin
      e.err = !(w == r[1]);
      e.lat = e.err ? 1 : (w ? LAT_W : LAT_R);
      if (!e.err && !w) m_rdata = (r == REG_TD) ? TD_VAL : TC_VAL;
      e.rdata = m_rdata;
      sb.push_back(e);
    end
  endtask

  task automatic wait_rsp(output int lat, output logic err, output logic [7:0] rd);
    lat = -1; err = 1'bx; rd = 8'hxx;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin lat = k; err = bus.rsp_err; rd = bus.rsp_rdata; break; end
    end
  endtask

  task automatic test_reset();
    logic [17:0] got, exp;
    int k;
    repeat (3) @(negedge clk);
    got = {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.bus_clk, bus.bus_reset, bus.bus_data_oe, bus.bus_data_o};
    exp = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    n_total++;
    if (got !== exp) $display("FAIL reset_values got %h exp %h", got, exp); else n_pass++;
    reset_n = 1'b1;
    k = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.req_ready === 1'b1) begin k = i; break; end
    end
    n_total++;
    if (k !== 2 * CD + 1) $display("FAIL init_ready_cycle got %0d exp %0d", k, 2 * CD + 1); else n_pass++;
  endtask

  task automatic test_read(input logic [1:0] r, input string nm);
    exp_t e; int lat; logic err; logic [7:0] rd; int c0, r0, q0;
    c0 = clk_rises; r0 = rst_rises; q0 = oe_log.size();
    issue(1'b0, r, 8'h00, 1'b1);
    wait_rsp(lat, err, rd);
    e = sb.pop_front();
    n_total++; if (lat !== e.lat) $display("FAIL %s_lat got %0d exp %0d", nm, lat, e.lat); else n_pass++;
    n_total++; if (err !== e.err) $display("FAIL %s_err got %0b exp %0b", nm, err, e.err); else n_pass++;
    n_total++; if (rd !== e.rdata) $display("FAIL %s_rdata got %h exp %h", nm, rd, e.rdata); else n_pass++;
    n_total++; if (clk_rises - c0 !== 2) $display("FAIL %s_clk_pulses got %0d exp 2", nm, clk_rises - c0); else n_pass++;
    n_total++; if (rst_rises - r0 !== RST_PER_TXN) $display("FAIL %s_bus_reset got %0d exp %0d", nm, rst_rises - r0, RST_PER_TXN); else n_pass++;
    n_total++;
    if (oe_log.size() < q0 + 2 || oe_log[q0 + 1] !== 1'b0) $display("FAIL %s_oe_sampling got %0d exp 0", nm, (oe_log.size() < q0 + 2) ? -1 : int'(oe_log[q0 + 1]));
    else n_pass++;
  endtask

  task automatic test_write_rd();
    exp_t e; int lat; logic err; logic [7:0] rd; int c0, n0; logic [11:0] nibs;
    c0 = clk_rises; n0 = nib_log.size();
    issue(1'b1, REG_RD, 8'hA5, 1'b1);
    wait_rsp(lat, err, rd);
    e = sb.pop_front();
    n_total++; if (lat !== e.lat) $display("FAIL write_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    n_total++; if (err !== e.err) $display("FAIL write_err got %0b exp %0b", err, e.err); else n_pass++;
    n_total++; if (s_rd !== 8'hA5) $display("FAIL write_slave_rd got %h exp a5", s_rd); else n_pass++;
    n_total++; if (clk_rises - c0 !== 3) $display("FAIL write_clk_pulses got %0d exp 3", clk_rises - c0); else n_pass++;
    nibs = (nib_log.size() >= n0 + 3) ? {nib_log[n0], nib_log[n0 + 1], nib_log[n0 + 2]} : 12'hfff;
    n_total++; if (nibs !== 12'h2A5) $display("FAIL write_nibbles got %h exp 2a5", nibs); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t ew, er; int lat; logic err; logic [7:0] rd; bit got;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin got = 1'b1; break; end
    end
    n_total++; if (!got) $display("FAIL b2b_ready got 0 exp 1 (timeout)"); else n_pass++;
    bus.req_write = 1'b1; bus.req_reg = REG_RC; bus.req_wdata = 8'h5A; bus.req_valid = 1'b1;
    ew.err = 1'b0; ew.lat = LAT_W; ew.rdata = m_rdata; sb.push_back(ew);
    @(posedge clk);
    // Valid stays high with new fields while the write is in flight; they must be ignored.
    #1 bus.req_write = 1'b0; bus.req_reg = REG_TD; bus.req_wdata = 8'h00;
    wait_rsp(lat, err, rd);
    ew = sb.pop_front();
    n_total++; if (lat !== ew.lat) $display("FAIL b2b_write_lat got %0d exp %0d", lat, ew.lat); else n_pass++;
    n_total++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_ready_in_done got %0b exp 0", bus.req_ready); else n_pass++;
    @(posedge clk); @(negedge clk);
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_after_done got %0b exp 1", bus.req_ready); else n_pass++;
    m_rdata = TD_VAL;
    er.err = 1'b0; er.lat = LAT_R; er.rdata = TD_VAL; sb.push_back(er);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp(lat, err, rd);
    er = sb.pop_front();
    n_total++; if (s_rc !== 8'h5A) $display("FAIL b2b_slave_rc got %h exp 5a", s_rc); else n_pass++;
    n_total++; if (lat !== er.lat) $display("FAIL b2b_read_lat got %0d exp %0d", lat, er.lat); else n_pass++;
    n_total++; if (rd !== er.rdata) $display("FAIL b2b_read_rdata got %h exp %h", rd, er.rdata); else n_pass++;
    n_total++; if (viol !== 0) $display("FAIL clk_oe_same_cycle got %0d exp 0", viol); else n_pass++;
  endtask

  task automatic test_illegal();
    logic       ws[2] = '{1'b1, 1'b0};
    logic [1:0] rs[2] = '{REG_TD, REG_RC};
    exp_t e; int lat; logic err; logic [7:0] rd; int c0, r0, o0;
    for (int i = 0; i < 2; i++) begin
      c0 = clk_rises; r0 = rst_rises; o0 = oe_hi;
      issue(ws[i], rs[i], 8'hFF, 1'b1);
      wait_rsp(lat, err, rd);
      repeat (2) @(negedge clk);
      e = sb.pop_front();
      n_total++; if (lat !== e.lat) $display("FAIL illegal%0d_lat got %0d exp %0d", i, lat, e.lat); else n_pass++;
      n_total++; if (err !== e.err) $display("FAIL illegal%0d_err got %0b exp %0b", i, err, e.err); else n_pass++;
      n_total++; if (rd !== e.rdata) $display("FAIL illegal%0d_rdata got %h exp %h", i, rd, e.rdata); else n_pass++;
      n_total++;
      if ((clk_rises - c0) + (rst_rises - r0) + (oe_hi - o0) !== 0)
        $display("FAIL illegal%0d_bus_quiet got %0d exp 0", i, (clk_rises - c0) + (rst_rises - r0) + (oe_hi - o0));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; logic err; logic [7:0] rd; int c0, v0, k; logic [3:0] got;
    c0 = clk_rises;
    issue(1'b1, REG_RD, 8'h3C, 1'b0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (clk_rises - c0 >= 2 && bus.bus_clk === 1'b1) break;
    end
    v0 = rsp_cnt;
    reset_n = 1'b0;
    #1 got = {bus.bus_clk, bus.bus_data_oe, bus.bus_reset, bus.rsp_valid};
    n_total++; if (got !== 4'b0010) $display("FAIL mid_reset_outputs got %b exp 0010", got); else n_pass++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_rdata = 8'h00;
    k = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.req_ready === 1'b1) begin k = i; break; end
    end
    n_total++; if (k !== 2 * CD + 1) $display("FAIL mid_reset_ready got %0d exp %0d", k, 2 * CD + 1); else n_pass++;
    n_total++; if (rsp_cnt !== v0) $display("FAIL mid_reset_no_rsp got %0d exp %0d", rsp_cnt - v0, 0); else n_pass++;
    n_total++; if (bus.rsp_rdata !== 8'h00) $display("FAIL mid_reset_rdata got %h exp 00", bus.rsp_rdata); else n_pass++;
    n_total++; if (s_rd !== 8'hA5) $display("FAIL mid_reset_slave_rd got %h exp a5", s_rd); else n_pass++;
    issue(1'b0, REG_TC, 8'h00, 1'b1);
    wait_rsp(lat, err, rd);
    e = sb.pop_front();
    n_total++; if (lat !== e.lat) $display("FAIL recover_lat got %0d exp %0d", lat, e.lat); else n_pass++;
    n_total++; if (rd !== e.rdata) $display("FAIL recover_rdata got %h exp %h", rd, e.rdata); else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_reg   = 2'd0;
    bus.req_wdata = 8'h00;
    test_reset();
    test_read(REG_TD, "read_td");
    test_read(REG_TC, "read_tc");
    test_write_rd();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
